// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
//   DEPTH-entry first-word-fall-through queue of fetched instruction words,
//   each stored with its PC tag. The head entry is presented as the current
//   instruction register with its MIPS fields split out. A flush discards all
//   queued words, for use on a branch or jump redirect.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   flush     discard all entries this cycle (overrides push/pop)
//   wr_en     push request from the fetch side
//   wr_data   instruction word to push
//   wr_pc     PC of wr_data
//   full      queue holds DEPTH entries
//   rd_en     consume the head instruction
//   ir_valid  head entry present
//   ir        head instruction word, 0 when !ir_valid
//   ir_pc     head PC tag, 0 when !ir_valid
//   count     occupancy, 0..DEPTH
//   opcode, rs, rt, rd, shamt, funct, imm
//             fields of ir (decode assumes DATA_W == 32)

module instr_prefetch_queue #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PC_W-1:0]   wr_pc,
  output logic              full,
  input  logic              rd_en,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir,
  output logic [PC_W-1:0]   ir_pc,
  output logic [CNT_W-1:0]  count,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic push_ok;
  logic pop_ok;
  logic [31:0] ir_word;

  assign ir_valid = (count_q != '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;

  assign pop_ok  = rd_en & ir_valid;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = wr_en & (~full | pop_ok);

  // Pointer and occupancy state. Flush drops any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage is never cleared; stale entries are unreachable once the
  // pointers and count are reset.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push_ok) begin
      data_mem[wr_ptr] <= wr_data;
      pc_mem[wr_ptr]   <= wr_pc;
    end
  end

  assign ir    = ir_valid ? data_mem[rd_ptr] : '0;
  assign ir_pc = ir_valid ? pc_mem[rd_ptr]   : '0;

  assign ir_word = 32'(ir);

  assign opcode = ir_word[31:26];
  assign rs     = ir_word[25:21];
  assign rt     = ir_word[20:16];
  assign rd     = ir_word[15:11];
  assign shamt  = ir_word[10:6];
  assign funct  = ir_word[5:0];
  assign imm    = ir_word[15:0];

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset, flush, wr_en, rd_en;
  logic [31:0] wr_data, wr_pc;
  logic        full, ir_valid;
  logic [31:0] ir, ir_pc;
  logic [2:0]  count;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instr_prefetch_queue #(.DATA_W(32), .PC_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_pc(wr_pc), .full(full), .rd_en(rd_en), .ir_valid(ir_valid), .ir(ir),
    .ir_pc(ir_pc), .count(count), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm)
  );

  typedef struct {
    logic        rst, fl, we, re;
    logic [31:0] wd, wp;
    int          ec;
    logic        ev, ef;
    logic [31:0] eir, epc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
  endtask

  task automatic add(input logic rst, input logic fl, input logic we, input logic re,
                     input logic [31:0] wd, input logic [31:0] wp, input int ec,
                     input logic ev, input logic ef, input logic [31:0] eir,
                     input logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.we = we; v.re = re; v.wd = wd; v.wp = wp;
    v.ec = ec; v.ev = ev; v.ef = ef; v.eir = eir; v.epc = epc;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, input logic fl, input logic we, input logic re,
                      input logic [31:0] wd, input logic [31:0] wp);
    reset = rst; flush = fl; wr_en = we; rd_en = re; wr_data = wd; wr_pc = wp;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input int idx, input int ec, input logic ev, input logic ef,
                           input logic [31:0] eir, input logic [31:0] epc);
    chk("count", idx, 32'(count), 32'(ec));
    chk("ir_valid", idx, 32'(ir_valid), 32'(ev));
    chk("full", idx, 32'(full), 32'(ef));
    chk("ir", idx, ir, eir);
    chk("ir_pc", idx, ir_pc, epc);
  endtask

  initial begin
    // Reset held two cycles while a push is requested: nothing is enqueued.
    step(1, 0, 1, 0, 32'hDEADBEEF, 32'h0000_0040);
    step(1, 0, 1, 0, 32'hDEADBEEF, 32'h0000_0040);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    chk_state(-1, 0, 0, 0, 32'h0, 32'h0);
    chk("opcode_rst", -1, 32'(opcode), 32'h0);
    chk("imm_rst", -1, 32'(imm), 32'h0);

    // FWFT + field decode: add $8,$9,$10
    step(0, 0, 1, 0, 32'h012A4020, 32'h0040_0000);
    chk_state(-2, 1, 1, 0, 32'h012A4020, 32'h0040_0000);
    chk("opcode", -2, 32'(opcode), 32'd0);
    chk("rs", -2, 32'(rs), 32'd9);
    chk("rt", -2, 32'(rt), 32'd10);
    chk("rd", -2, 32'(rd), 32'd8);
    chk("shamt", -2, 32'(shamt), 32'd0);
    chk("funct", -2, 32'(funct), 32'h20);
    chk("imm", -2, 32'(imm), 32'h4020);

    // I-type decode: lw $5, 0x1234($4) = 0x8C851234, pushed behind the add
    step(0, 0, 1, 1, 32'h8C851234, 32'h0040_0004);
    chk_state(-3, 1, 1, 0, 32'h8C851234, 32'h0040_0004);
    chk("opcode_lw", -3, 32'(opcode), 32'h23);
    chk("rs_lw", -3, 32'(rs), 32'd4);
    chk("rt_lw", -3, 32'(rt), 32'd5);
    chk("imm_lw", -3, 32'(imm), 32'h1234);

    //   rst fl we re  wd     wp      ec ev ef eir     epc
    add(0, 0, 0, 1, 32'h0, 32'h0,    0, 0, 0, 32'h0, 32'h0);   // drain
    add(0, 0, 0, 1, 32'h0, 32'h0,    0, 0, 0, 32'h0, 32'h0);   // pop on empty
    // Fill 1..4, word 5 dropped
    add(0, 0, 1, 0, 32'd1, 32'h100,  1, 1, 0, 32'd1, 32'h100);
    add(0, 0, 1, 0, 32'd2, 32'h104,  2, 1, 0, 32'd1, 32'h100);
    add(0, 0, 1, 0, 32'd3, 32'h108,  3, 1, 0, 32'd1, 32'h100);
    add(0, 0, 1, 0, 32'd4, 32'h10C,  4, 1, 1, 32'd1, 32'h100);
    add(0, 0, 1, 0, 32'd5, 32'h110,  4, 1, 1, 32'd1, 32'h100);
    // Full with push 9 + pop: count stays 4, order 2,3,4,9
    add(0, 0, 1, 1, 32'd9, 32'h124,  4, 1, 1, 32'd2, 32'h104);
    add(0, 0, 0, 1, 32'h0, 32'h0,    3, 1, 0, 32'd3, 32'h108);
    add(0, 0, 0, 1, 32'h0, 32'h0,    2, 1, 0, 32'd4, 32'h10C);
    add(0, 0, 0, 1, 32'h0, 32'h0,    1, 1, 0, 32'd9, 32'h124);
    add(0, 0, 0, 1, 32'h0, 32'h0,    0, 0, 0, 32'h0, 32'h0);
    // Empty with push 7 + pop: enqueued, no underflow
    add(0, 0, 1, 1, 32'd7, 32'h200,  1, 1, 0, 32'd7, 32'h200);
    add(0, 0, 0, 0, 32'h0, 32'h0,    1, 1, 0, 32'd7, 32'h200);
    // Grow to 3 (7,A,B), then flush with push 8 + pop
    add(0, 0, 1, 0, 32'hA, 32'h204,  2, 1, 0, 32'd7, 32'h200);
    add(0, 0, 1, 0, 32'hB, 32'h208,  3, 1, 0, 32'd7, 32'h200);
    add(0, 1, 1, 1, 32'd8, 32'h300,  0, 0, 0, 32'h0, 32'h0);
    add(0, 0, 0, 0, 32'h0, 32'h0,    0, 0, 0, 32'h0, 32'h0);
    add(0, 0, 1, 0, 32'd8, 32'h300,  1, 1, 0, 32'd8, 32'h300);
    add(0, 0, 1, 0, 32'hC, 32'h304,  2, 1, 0, 32'd8, 32'h300);
    // Reset mid-stream with push: no stale word reappears
    add(1, 0, 1, 1, 32'hE, 32'h400,  0, 0, 0, 32'h0, 32'h0);
    add(0, 0, 0, 1, 32'h0, 32'h0,    0, 0, 0, 32'h0, 32'h0);
    add(0, 0, 1, 0, 32'hF, 32'h500,  1, 1, 0, 32'hF, 32'h500);
    add(0, 0, 0, 1, 32'h0, 32'h0,    0, 0, 0, 32'h0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].fl, vecs[i].we, vecs[i].re, vecs[i].wd, vecs[i].wp);
      chk_state(i, vecs[i].ec, vecs[i].ev, vecs[i].ef, vecs[i].eir, vecs[i].epc);
    end

    // Wrap the pointers several times with steady push+pop streaming.
    step(0, 0, 1, 0, 32'h1000, 32'h1000);
    for (int k = 1; k < 12; k++) begin
      step(0, 0, 1, 1, 32'h1000 + 32'(k), 32'h1000 + 32'(4 * k));
      chk_state(100 + k, 1, 1, 0, 32'h1000 + 32'(k), 32'h1000 + 32'(4 * k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Parametrised successor to the single-entry instruction register: a DEPTH-entry first-word-fall-through queue of fetched instruction words, each tagged with its PC. The memory/fetch side pushes words with a write enable. The control FSM consumes the head word as the current instruction register and sees its MIPS fields pre-split. A flush input discards all queued words on a branch or jump redirect.

Parameters:
DATA_W, 32, instruction word width (field decode is defined for 32 only)
PC_W, 32, width of the PC tag stored with each word
DEPTH, 4, number of queue entries; power of two, >= 2
CNT_W (localparam), $clog2(DEPTH)+1, width of occupancy count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-high reset
flush  input  1  discard all entries this cycle
wr_en  input  1  push request (successor of IRwrite)
wr_data  input  DATA_W  instruction word from memory
wr_pc  input  PC_W  address of wr_data
full  output  1  queue holds DEPTH entries
rd_en  input  1  consume head instruction
ir_valid  output  1  head entry present
ir  output  DATA_W  head instruction word; 0 when !ir_valid
ir_pc  output  PC_W  head PC tag; 0 when !ir_valid
count  output  CNT_W  current occupancy, 0..DEPTH
opcode  output  6  ir[31:26]
rs  output  5  ir[25:21]
rt  output  5  ir[20:16]
rd  output  5  ir[15:11]
shamt  output  5  ir[10:6]
funct  output  6  ir[5:0]
imm  output  16  ir[15:0]

Behaviour:
- Reset: all state updates on posedge clk. With reset=1, the next edge gives wr_ptr=rd_ptr=0 and count=0, so ir_valid=0, full=0, ir=0, ir_pc=0 and all fields are 0. Storage array contents are don't-care and are not cleared.
- Priority at each edge: reset > flush > push/pop.
- push_ok = wr_en & (!full | pop_ok). pop_ok = rd_en & ir_valid.
- Push writes {wr_data, wr_pc} at wr_ptr, then wr_ptr = wr_ptr+1 mod DEPTH. Pop advances rd_ptr the same way.
- count next = count + push_ok - pop_ok. Simultaneous push and pop leaves count unchanged.
- Full with simultaneous pop: the push is accepted.
- Full without pop: wr_en is ignored, and storage and pointers are unchanged.
- Empty: rd_en is ignored. Empty with simultaneous push: the word is enqueued and the pop is not taken; the word appears at the head next cycle.
- Latency: a word pushed at edge N is visible on ir/ir_pc/fields after edge N (FWFT, zero bubble). There is no write-through bypass to the same-cycle output.
- Outputs ir_valid = (count != 0) and full = (count == DEPTH) are decoded combinationally from count. ir/ir_pc are gated to 0 when !ir_valid; the decoded fields follow the gated ir.
- Flush: the next edge gives count=0 and rd_ptr=wr_ptr=0. A wr_en asserted in the same cycle is dropped, and rd_en is ignored.
- Reset or flush mid-stream: any partially consumed contents are lost and no stale word reappears. Pointers wrap freely; there is no overflow or underflow state.
- Outputs are stable between edges; nothing changes on negedge.

Test Plan:
- Reset check: assert reset for 2 cycles with wr_en=1 and wr_data=32'hDEADBEEF -> count=0, ir_valid=0, ir=0, full=0 after release.
- FWFT and decode: push 32'h012A4020 (add $8,$9,$10) with pc 32'h00400000 -> next cycle ir_valid=1, opcode=0, rs=9, rt=10, rd=8, shamt=0, funct=6'h20, ir_pc=32'h00400000.
- Fill and overflow: push 5 words 1..5 with DEPTH=4 and no rd_en -> full=1, count=4, word 5 dropped; then pop 4 times -> ir sequence 1,2,3,4, then ir_valid=0.
- Full with simultaneous push and pop: with the queue full of 1..4, push 9 and pop in the same cycle -> count stays 4, and the pop order continues 2,3,4,9.
- Empty with simultaneous push and pop: with count=0, push 7 with rd_en=1 -> count=1 and ir=7 next cycle, no underflow.
- Flush: with count=3, assert flush with wr_en=1 (data 8) -> count=0 and ir_valid=0 next cycle; a following push of 8 appears as ir=8 with count=1.
